mem_ctl: RTL and testbench

MEM_CTL -- requirements
Module: mem_ctl

---
 rtl/mem_ctl_if.sv | 55 +++++
 rtl/mem_ctl.sv | 169 ++++++++++++++++
 tb/tb_mem_ctl.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_ctl_if.sv
// mem_ctl_if: CPU request/response channel and external SRAM bus for mem_ctl.
// Ports: slave = controller view, master = CPU plus memory-model view.
interface mem_ctl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [15:0] req_addr;
    logic [7:0]  req_wdata;
    logic [3:0]  req_dst;
    logic        mem_res;
    logic [7:0]  data_out;
    logic [3:0]  res_dst;
    logic [15:0] bus_addr;
    logic [7:0]  bus_wdata;
    logic [7:0]  bus_rdata;
    logic        bus_cs_n;
    logic        bus_oe_n;
    logic        bus_we_n;

    modport slave (
        input  req_valid,
        input  req_we,
        input  req_addr,
        input  req_wdata,
        input  req_dst,
        input  bus_rdata,
        output req_ready,
        output mem_res,
        output data_out,
        output res_dst,
        output bus_addr,
        output bus_wdata,
        output bus_cs_n,
        output bus_oe_n,
        output bus_we_n
    );

    modport master (
        output req_valid,
        output req_we,
        output req_addr,
        output req_wdata,
        output req_dst,
        output bus_rdata,
        input  req_ready,
        input  mem_res,
        input  data_out,
        input  res_dst,
        input  bus_addr,
        input  bus_wdata,
        input  bus_cs_n,
        input  bus_oe_n,
        input  bus_we_n
    );
endinterface

// File: rtl/mem_ctl.sv
// mem_ctl: async-SRAM style controller, IDLE/SETUP/STROBE(xWAIT_CYCLES)/HOLD.
// Ports: cpu_clk, cpu_rst (async, active low), ifc (mem_ctl_if.slave):
//   req_* request in with valid/ready, mem_res/data_out/res_dst read response,
//   bus_* external address/data and active-low cs/oe/we strobes.
// Optional MEM_CTL_QUEUE_EN adds a 2-entry request FIFO so accesses can
// chain HOLD -> SETUP; without it a request is only taken in IDLE.
module mem_ctl #(
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic     cpu_clk,
    input  logic     cpu_rst,
    mem_ctl_if.slave ifc
);
    localparam logic [3:0] LP_WAIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_HOLD
    } state_t;

    typedef struct packed {
        logic        we;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic [3:0]  dst;
    } req_t;

    state_t     r_state;
    state_t     w_state_nx;
    req_t       r_act;
    req_t       w_in;
    req_t       w_next_req;
    logic [3:0] r_cnt;
    logic [7:0] r_rdata;
    logic [3:0] r_res_dst;
    logic       w_ready;
    logic       w_accept;
    logic       w_load;
    logic       w_last;

    assign w_in     = {ifc.req_we, ifc.req_addr, ifc.req_wdata, ifc.req_dst};
    assign w_accept = ifc.req_valid & w_ready;
    // Final strobe cycle; <= guards against a zero count ever stalling.
    assign w_last   = (r_cnt <= 4'd1);

`ifdef MEM_CTL_QUEUE_EN
    req_t       r_fifo [2];
    logic       r_wptr;
    logic       r_rptr;
    logic [1:0] r_count;
    logic       w_full;
    logic       w_empty;
    logic       w_pop;
    logic       w_bypass;
    logic       w_push;

    assign w_full  = (r_count == 2'd2);
    assign w_empty = (r_count == 2'd0);
    // A full FIFO can still take a request in HOLD, since it pops there.
    assign w_ready = cpu_rst & (~w_full | (r_state == S_HOLD));
    assign w_pop   = (r_state == S_HOLD) & ~w_empty;
    // With nothing queued, a request taken in IDLE/HOLD goes straight
    // to SETUP so its latency matches the unqueued case.
    assign w_bypass = w_accept & w_empty &
                      ((r_state == S_IDLE) | (r_state == S_HOLD));
    assign w_push     = w_accept & ~w_bypass;
    assign w_load     = w_pop | w_bypass;
    assign w_next_req = w_pop ? r_fifo[r_rptr] : w_in;

    always_ff @(posedge cpu_clk) begin
        if (w_push) begin
            r_fifo[r_wptr] <= w_in;
        end
    end

    always_ff @(posedge cpu_clk or negedge cpu_rst) begin
        if (!cpu_rst) begin
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_push) begin
                r_wptr <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end
`else
    assign w_ready    = cpu_rst & (r_state == S_IDLE);
    assign w_load     = w_accept;
    assign w_next_req = w_in;
`endif

    always_ff @(posedge cpu_clk or negedge cpu_rst) begin
        if (!cpu_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_load) begin
                    w_state_nx = S_SETUP;
                end
            end
            S_SETUP: begin
                w_state_nx = S_STROBE;
            end
            S_STROBE: begin
                if (w_last) begin
                    w_state_nx = S_HOLD;
                end
            end
            S_HOLD: begin
                w_state_nx = w_load ? S_SETUP : S_IDLE;
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge cpu_clk or negedge cpu_rst) begin
        if (!cpu_rst) begin
            r_act     <= '0;
            r_cnt     <= 4'd0;
            r_rdata   <= 8'h00;
            r_res_dst <= 4'h0;
        end else begin
            if (w_load) begin
                r_act <= w_next_req;
            end
            if (r_state == S_SETUP) begin
                r_cnt <= LP_WAIT;
            end else if ((r_state == S_STROBE) && !w_last) begin
                r_cnt <= r_cnt - 4'd1;
            end
            // Tag is copied alongside the data: r_act may be reloaded
            // for the next access while this response is on display.
            if ((r_state == S_STROBE) && w_last && !r_act.we) begin
                r_rdata   <= ifc.bus_rdata;
                r_res_dst <= r_act.dst;
            end
        end
    end

    assign ifc.req_ready = w_ready;
    assign ifc.mem_res   = (r_state == S_HOLD) & ~r_act.we;
    assign ifc.data_out  = r_rdata;
    assign ifc.res_dst   = r_res_dst;
    assign ifc.bus_addr  = r_act.addr;
    assign ifc.bus_wdata = r_act.wdata;
    assign ifc.bus_cs_n  = (r_state == S_IDLE);
    assign ifc.bus_oe_n  = ~((r_state == S_STROBE) & ~r_act.we);
    assign ifc.bus_we_n  = ~((r_state == S_STROBE) & r_act.we);
endmodule

// File: tb/tb_mem_ctl.sv
// tb_mem_ctl: scoreboard bench for mem_ctl (WAIT_CYCLES 2, 1 and 15).
// Honours MEM_CTL_QUEUE_EN for the back-to-back request scenario.
`timescale 1ns/1ps
module tb_mem_ctl;
    localparam int W = 2;
`ifdef MEM_CTL_QUEUE_EN
    localparam logic QEN = 1'b1;
`else
    localparam logic QEN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_run = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_ctl_if m();
    mem_ctl_if a1();
    mem_ctl_if a15();

    mem_ctl #(.WAIT_CYCLES(W)) dut (
        .cpu_clk(clk),
        .cpu_rst(rst_n),
        .ifc    (m)
    );
    mem_ctl #(.WAIT_CYCLES(1)) dut_w1 (
        .cpu_clk(clk),
        .cpu_rst(rst_n),
        .ifc    (a1)
    );
    mem_ctl #(.WAIT_CYCLES(15)) dut_w15 (
        .cpu_clk(clk),
        .cpu_rst(rst_n),
        .ifc    (a15)
    );

    function automatic logic [7:0] mem_f(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h81;
    endfunction

    assign m.bus_rdata   = mem_f(m.bus_addr);
    assign a1.bus_rdata  = mem_f(a1.bus_addr);
    assign a15.bus_rdata = mem_f(a15.bus_addr);

    typedef struct packed {
        logic [3:0] dst;
        logic [7:0] data;
    } exp_t;
    exp_t sb[$];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (m.mem_res === 1'b1) begin
            if (sb.size() == 0) begin
                check("res_unexpected", 32'(m.mem_res), 32'd0);
            end else begin
                e = sb.pop_front();
                check("rd_data", 32'(m.data_out), 32'(e.data));
                check("rd_dst", 32'(m.res_dst), 32'(e.dst));
            end
        end
        if (m.bus_oe_n === 1'b0 && m.bus_we_n === 1'b0) begin
            check("oe_we_both_low", 32'(m.bus_we_n), 32'd1);
        end
    end

    task automatic access(input logic we, input logic [15:0] a,
                          input logic [7:0] wd, input logic [3:0] d);
        int   k;
        logic strobe;
        m.req_valid = 1'b1;
        m.req_we    = we;
        m.req_addr  = a;
        m.req_wdata = wd;
        m.req_dst   = d;
        k = 0;
        while (m.req_ready !== 1'b1 && k < 50) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (k >= 50) begin
            check("accept_timeout", 32'(m.req_ready), 32'd1);
            m.req_valid = 1'b0;
            return;
        end
        if (!we) sb.push_back({d, mem_f(a)});
        @(posedge clk);
        #1;
        m.req_valid = 1'b0;
        for (int c = 0; c < W + 2; c++) begin
            @(negedge clk);
            strobe = (c >= 1) && (c <= W);
            check("cs_n", 32'(m.bus_cs_n), 32'd0);
            check("oe_n", 32'(m.bus_oe_n), 32'(!(strobe && !we)));
            check("we_n", 32'(m.bus_we_n), 32'(!(strobe && we)));
            check("bus_addr", 32'(m.bus_addr), 32'(a));
            check("busy_rdy", 32'(m.req_ready), 32'(QEN));
            check("mem_res", 32'(m.mem_res), 32'((c == W + 1) && !we));
            if (we) check("bus_wdata", 32'(m.bus_wdata), 32'(wd));
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1);
    end

    initial begin
        int i, n, t, idle, gap;
        int k0, s1, s15, l1, l15, p1, p15;
        int acc[$];
        m.req_valid = 1'b0;
        m.req_we    = 1'b0;
        m.req_addr  = 16'h0;
        m.req_wdata = 8'h0;
        m.req_dst   = 4'h0;
        a1.req_valid  = 1'b0;
        a1.req_we     = 1'b0;
        a1.req_addr   = 16'h0;
        a1.req_wdata  = 8'h0;
        a1.req_dst    = 4'h0;
        a15.req_valid = 1'b0;
        a15.req_we    = 1'b0;
        a15.req_addr  = 16'h0;
        a15.req_wdata = 8'h0;
        a15.req_dst   = 4'h0;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 32'(m.req_ready), 32'd0);
        check("rst_mem_res", 32'(m.mem_res), 32'd0);
        check("rst_data_out", 32'(m.data_out), 32'h00);
        check("rst_res_dst", 32'(m.res_dst), 32'h0);
        check("rst_bus_addr", 32'(m.bus_addr), 32'h0000);
        check("rst_bus_wdata", 32'(m.bus_wdata), 32'h00);
        check("rst_cs_n", 32'(m.bus_cs_n), 32'd1);
        check("rst_oe_n", 32'(m.bus_oe_n), 32'd1);
        check("rst_we_n", 32'(m.bus_we_n), 32'd1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("idle_ready", 32'(m.req_ready), 32'd1);
        @(posedge clk);
        #1;

        access(1'b0, 16'h1234, 8'h00, 4'h5);
        @(negedge clk);
        check("after_rd_cs_n", 32'(m.bus_cs_n), 32'd1);
        check("hold_data", 32'(m.data_out), 32'hA7);
        check("hold_dst", 32'(m.res_dst), 32'h5);
        @(posedge clk);
        #1;
        access(1'b1, 16'h00FF, 8'h3C, 4'h9);
        @(negedge clk);
        check("wr_keeps_data", 32'(m.data_out), 32'hA7);
        check("wr_keeps_dst", 32'(m.res_dst), 32'h5);
        @(posedge clk);
        #1;
        access(1'b0, 16'hABCD, 8'h00, 4'hF);
        @(posedge clk);
        #1;
        access(1'b1, 16'hFFFF, 8'hFF, 4'h0);
        @(posedge clk);
        #1;
        access(1'b0, 16'h0000, 8'h00, 4'h1);
        @(posedge clk);
        #1;

        check("pre_rst_ready", 32'(m.req_ready), 32'd1);
        m.req_valid = 1'b1;
        m.req_we    = 1'b0;
        m.req_addr  = 16'h5555;
        m.req_dst   = 4'h7;
        @(posedge clk);
        #1 m.req_valid = 1'b0;
        @(posedge clk);
        #1;
        check("strobe_oe_n", 32'(m.bus_oe_n), 32'd0);
        rst_n = 1'b0;
        #1;
        check("midrst_cs_n", 32'(m.bus_cs_n), 32'd1);
        check("midrst_oe_n", 32'(m.bus_oe_n), 32'd1);
        check("midrst_we_n", 32'(m.bus_we_n), 32'd1);
        check("midrst_ready", 32'(m.req_ready), 32'd0);
        check("midrst_addr", 32'(m.bus_addr), 32'h0000);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("sb_after_rst", 32'(sb.size()), 32'd0);
        access(1'b0, 16'h1357, 8'h00, 4'h3);
        @(posedge clk);
        #1;

`ifdef MEM_CTL_QUEUE_EN
        n = 3;
`else
        n = 2;
`endif
        i = 0;
        t = 0;
        idle = 0;
        m.req_valid = 1'b1;
        m.req_we    = 1'b0;
        m.req_addr  = 16'h2000;
        m.req_dst   = 4'h1;
        while (i < n && t < 100) begin
            @(negedge clk);
            #1;
            t++;
            if (acc.size() > 0 && m.bus_cs_n === 1'b1) idle++;
            if (m.req_ready === 1'b1) begin
                sb.push_back({4'(i + 1), mem_f(16'(16'h2000 + i))});
                @(posedge clk);
                #1;
                acc.push_back(cyc);
                i++;
                if (i < n) begin
                    m.req_addr = 16'(16'h2000 + i);
                    m.req_dst  = 4'(i + 1);
                end else begin
                    m.req_valid = 1'b0;
                end
            end
        end
        m.req_valid = 1'b0;
        check("stream_accepts", 32'(i), 32'(n));
        @(negedge clk);
        #1;
        check("rdy_after_fill", 32'(m.req_ready), 32'd0);
        if (sb.size() > 0 && m.bus_cs_n === 1'b1) idle++;
        while (sb.size() > 0 && t < 100) begin
            @(negedge clk);
            #1;
            t++;
            if (sb.size() > 0 && m.bus_cs_n === 1'b1) idle++;
        end
        check("stream_drain", 32'(sb.size()), 32'd0);
        if (acc.size() == n) begin
            gap = acc[1] - acc[0];
`ifdef MEM_CTL_QUEUE_EN
            check("q_gap01", 32'(gap), 32'd1);
            check("q_gap12", 32'(acc[2] - acc[1]), 32'd1);
            check("q_idle", 32'(idle), 32'd0);
`else
            check("nq_gap", 32'(gap), 32'(W + 3));
            check("nq_idle", 32'(idle >= 1), 32'd1);
`endif
        end
        @(posedge clk);
        #1;

        check("w1_rdy", 32'(a1.req_ready), 32'd1);
        check("w15_rdy", 32'(a15.req_ready), 32'd1);
        a1.req_valid  = 1'b1;
        a1.req_addr   = 16'h0F3C;
        a1.req_dst    = 4'hB;
        a15.req_valid = 1'b1;
        a15.req_addr  = 16'hC0DE;
        a15.req_dst   = 4'h6;
        @(posedge clk);
        #1;
        k0 = cyc;
        a1.req_valid  = 1'b0;
        a15.req_valid = 1'b0;
        s1 = 0;
        s15 = 0;
        p1 = 0;
        p15 = 0;
        l1 = -1;
        l15 = -1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (a1.bus_oe_n === 1'b0) s1++;
            if (a15.bus_oe_n === 1'b0) s15++;
            if (a1.mem_res === 1'b1) begin
                p1++;
                if (l1 < 0) begin
                    l1 = cyc - k0;
                    check("w1_data", 32'(a1.data_out), 32'(mem_f(16'h0F3C)));
                    check("w1_dst", 32'(a1.res_dst), 32'hB);
                end
            end
            if (a15.mem_res === 1'b1) begin
                p15++;
                if (l15 < 0) begin
                    l15 = cyc - k0;
                    check("w15_data", 32'(a15.data_out), 32'(mem_f(16'hC0DE)));
                    check("w15_dst", 32'(a15.res_dst), 32'h6);
                end
            end
        end
        check("w1_strobe_len", 32'(s1), 32'd1);
        check("w15_strobe_len", 32'(s15), 32'd15);
        check("w1_latency", 32'(l1), 32'd2);
        check("w15_latency", 32'(l15), 32'd16);
        check("w1_res_width", 32'(p1), 32'd1);
        check("w15_res_width", 32'(p15), 32'd1);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
